// File: rtl/mic_dma_pkg.sv
// Shared types and bus constants for the mic DMA blocks.
package mic_dma_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_t;

   localparam logic [2:0]  AM_BURST_ONE = 3'd1;
   localparam logic [3:0]  AM_BE_ALL    = 4'hF;
   localparam logic [31:0] WORD_BYTES   = 32'd4;

endpackage

// File: rtl/mic_sync_fifo.sv
// Show-ahead synchronous FIFO with simultaneous push/pop.
module mic_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);
   import mic_dma_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   // Head is forced to zero when empty so the stream never shows stale storage.
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/mic_rd_dma.sv
// Avalon-MM read master: streams a contiguous block of sample words out in address order.
module mic_rd_dma #(
   parameter int DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [31:0] AM_ADDR,
   output logic [2:0]  AM_BURSTCOUNT,
   output logic [3:0]  AM_BYTEENABLE,
   output logic        AM_READ,
   input  logic        AM_WAITREQUEST,
   input  logic [31:0] AM_READDATA,
   input  logic        AM_READDATAVALID,
   input  logic        start,
   input  logic [31:0] start_address,
   input  logic [31:0] number_samples,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        BUSY,
   output logic        FINISHED
);
   import mic_dma_pkg::*;

   localparam int           CW         = $clog2(DEPTH) + 1;
   localparam logic [CW:0]  CREDIT_MAX = (CW+1)'(DEPTH);

   rd_state_t       state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     remaining_q, remaining_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;

   logic [CW-1:0]   fifo_count;
   logic            fifo_empty, fifo_full;
   logic [CW:0]     credit;
   logic            active, accept, push, pop;

   // Reads in flight plus words buffered may never exceed the FIFO depth.
   assign credit  = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign AM_READ = (state_q == ISSUE) && (remaining_q != 32'd0) &&
                    (credit < CREDIT_MAX) && !fifo_full;
   assign AM_ADDR = (state_q == ISSUE) ? addr_q : 32'd0;
   assign AM_BURSTCOUNT = AM_BURST_ONE;
   assign AM_BYTEENABLE = AM_BE_ALL;

   assign active = (state_q == ISSUE) || (state_q == DRAIN);
   assign accept = AM_READ && !AM_WAITREQUEST;
   assign push   = AM_READDATAVALID && active;
   assign pop    = !fifo_empty && out_ready;

   assign out_valid = !fifo_empty;
   assign BUSY      = active;
   assign FINISHED  = (state_q == DONE);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      remaining_d   = remaining_q;
      outstanding_d = outstanding_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (number_samples != 32'd0) begin
                  state_d     = ISSUE;
                  addr_d      = {start_address[31:2], 2'b00};
                  remaining_d = number_samples;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ISSUE: begin
            if (accept) begin
               addr_d      = addr_q + WORD_BYTES;
               remaining_d = remaining_q - 32'd1;
               if (remaining_q == 32'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (outstanding_q == '0 && fifo_empty) state_d = DONE;
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      case ({accept, push})
         2'b10:   outstanding_d = outstanding_q + CW'(1);
         2'b01:   outstanding_d = (outstanding_q != '0) ? outstanding_q - CW'(1) : outstanding_q;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= IDLE;
         addr_q        <= 32'd0;
         remaining_q   <= 32'd0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         outstanding_q <= outstanding_d;
      end
   end

   mic_sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push_i  (push),
      .din_i   (AM_READDATA),
      .pop_i   (pop),
      .dout_o  (out_data),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

endmodule

// File: tb/tb_mic_rd_dma.sv
// Bench for mic_rd_dma: randomized Avalon slave and stream sink checked against an address-order model.
module tb_mic_rd_dma;

   localparam int DEPTH = 8;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] AM_ADDR;
   logic [2:0]  AM_BURSTCOUNT;
   logic [3:0]  AM_BYTEENABLE;
   logic        AM_READ;
   logic        AM_WAITREQUEST = 1'b0;
   logic [31:0] AM_READDATA = 32'd0;
   logic        AM_READDATAVALID = 1'b0;
   logic        start = 1'b0;
   logic [31:0] start_address = 32'd0;
   logic [31:0] number_samples = 32'd0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        BUSY;
   logic        FINISHED;

   mic_rd_dma #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET),
      .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_BYTEENABLE(AM_BYTEENABLE),
      .AM_READ(AM_READ), .AM_WAITREQUEST(AM_WAITREQUEST), .AM_READDATA(AM_READDATA),
      .AM_READDATAVALID(AM_READDATAVALID),
      .start(start), .start_address(start_address), .number_samples(number_samples),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .BUSY(BUSY), .FINISHED(FINISHED)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Memory contents: each word holds its own byte address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a;
   endfunction

   typedef struct { int due; logic [31:0] data; } resp_t;
   resp_t       resp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   // Slave / sink knobs, written by the main sequence
   int wait_pct = 0, ready_pct = 100, lat = 1, acc_limit = 1 << 30;
   int stall_idx = -1, stall_left = 0, stall_hits = 0;
   int acc_cnt = 0, pop_cnt = 0, read_cycles = 0, cyc = 0;
   logic [31:0] first_addr = 0, last_addr = 0;

   logic        wr_v, prev_stalled = 1'b0;
   logic [31:0] prev_addr = 0;

   // Avalon slave, stream sink and protocol monitor, all acting on the falling edge.
   initial begin
      forever begin
         @(negedge CLK);
         cyc++;
         if (prev_stalled && !RESET) begin
            chk("stall_read_stable", {31'd0, AM_READ}, 32'd1);
            chk("stall_addr_stable", AM_ADDR, prev_addr);
         end
         if (AM_READ) read_cycles++;
         AM_READDATAVALID = 1'b0;
         AM_READDATA      = $urandom;
         if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            resp_t r;
            r = resp_q.pop_front();
            AM_READDATAVALID = 1'b1;
            AM_READDATA      = r.data;
         end
         if (AM_READ && acc_cnt == stall_idx && stall_left > 0) begin
            wr_v = 1'b1;
            stall_left--;
            stall_hits++;
            if (exp_addr_q.size() > 0) chk("stall_addr", AM_ADDR, exp_addr_q[0]);
         end else begin
            wr_v = ($urandom_range(99) < wait_pct) || (acc_cnt >= acc_limit);
         end
         AM_WAITREQUEST = wr_v;
         if (AM_READ && !wr_v) begin
            if (acc_cnt == 0) first_addr = AM_ADDR;
            last_addr = AM_ADDR;
            acc_cnt++;
            if (exp_addr_q.size() > 0) chk("read_addr", AM_ADDR, exp_addr_q.pop_front());
            else chk("extra_read", 32'd1, 32'd0);
            chk("credit_le_depth", {31'd0, (acc_cnt - pop_cnt) <= DEPTH}, 32'd1);
            resp_q.push_back('{cyc + lat, mem_word(AM_ADDR)});
         end
         prev_stalled = AM_READ && wr_v;
         prev_addr    = AM_ADDR;
         out_ready = ($urandom_range(99) < ready_pct);
         if (out_valid && out_ready) begin
            pop_cnt++;
            if (exp_data_q.size() > 0) chk("out_data", out_data, exp_data_q.pop_front());
            else chk("extra_word", 32'd1, 32'd0);
         end
      end
   end

   task automatic step();
      @(negedge CLK);
      #2;
   endtask

   task automatic fill_exp(input logic [31:0] a, input int n);
      logic [31:0] base;
      exp_addr_q.delete();
      exp_data_q.delete();
      base = {a[31:2], 2'b00};
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(base + 32'(4 * i));
         exp_data_q.push_back(mem_word(base + 32'(4 * i)));
      end
      acc_cnt = 0;
      pop_cnt = 0;
   endtask

   task automatic wait_finished(input string nm);
      for (int c = 0; c < 4000 && !FINISHED; c++) step();
      chk({nm, "_finished"}, {31'd0, FINISHED}, 32'd1);
   endtask

   task automatic run_xfer(input string nm, input logic [31:0] a, input int n,
                           input int wp, input int rp, input int lt,
                           input logic [31:0] ef, input logic [31:0] el);
      fill_exp(a, n);
      wait_pct = wp; ready_pct = rp; lat = lt;
      start_address = a; number_samples = n; start = 1'b1;
      step();
      chk({nm, "_first_read"}, {31'd0, AM_READ}, 32'd1);
      chk({nm, "_first_addr"}, AM_ADDR, ef);
      wait_finished(nm);
      chk({nm, "_accepts"}, acc_cnt, n);
      chk({nm, "_words"}, pop_cnt, n);
      chk({nm, "_first"}, first_addr, ef);
      chk({nm, "_last"}, last_addr, el);
      step();
      chk({nm, "_hold_done"}, {30'd0, FINISHED, AM_READ}, 32'd2);
      start = 1'b0;
      step();
      chk({nm, "_idle"}, {30'd0, FINISHED, BUSY}, 32'd0);
   endtask

   typedef struct {
      string       nm;
      logic [31:0] a;
      int          n, wp, rp, lt;
      logic [31:0] ef, el;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{"normal",   32'h0000_1000,  4,  0, 100, 2, 32'h0000_1000, 32'h0000_100C});
      vecs.push_back('{"unalign",  32'h0000_2003,  2,  0, 100, 1, 32'h0000_2000, 32'h0000_2004});
      vecs.push_back('{"wrap",     32'hFFFF_FFF8,  4, 30,  70, 3, 32'hFFFF_FFF8, 32'h0000_0004});
      vecs.push_back('{"busy_bus", 32'h8000_0010, 25, 40,  50, 4, 32'h8000_0010, 32'h8000_0070});
      vecs.push_back('{"lat1",     32'h0000_0000,  9, 20,  90, 1, 32'h0000_0000, 32'h0000_0020});

      // Reset state
      repeat (2) step();
      chk("rst_outputs", {26'd0, AM_READ, out_valid, BUSY, FINISHED, 2'b00}, 32'd0);
      chk("rst_addr", AM_ADDR, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("bus_consts", {25'd0, AM_BURSTCOUNT, AM_BYTEENABLE}, 32'h1F);
      RESET = 1'b0;
      step();

      foreach (vecs[i])
         run_xfer(vecs[i].nm, vecs[i].a, vecs[i].n, vecs[i].wp, vecs[i].rp, vecs[i].lt,
                  vecs[i].ef, vecs[i].el);

      // Waitrequest held three cycles on the second read
      stall_idx = 1; stall_left = 3; stall_hits = 0;
      run_xfer("stall", 32'h0000_1000, 4, 0, 100, 2, 32'h0000_1000, 32'h0000_100C);
      chk("stall_cycles", stall_hits, 3);
      stall_idx = -1;

      // Zero length
      read_cycles = 0;
      start_address = 32'h0000_4000; number_samples = 0; start = 1'b1;
      step();
      chk("zero_finished", {31'd0, FINISHED}, 32'd1);
      chk("zero_busy", {31'd0, BUSY}, 32'd0);
      step();
      chk("zero_no_read", read_cycles, 0);
      start = 1'b0;
      step();
      chk("zero_idle", {31'd0, FINISHED}, 32'd0);

      // Backpressure: sink stalled, issue must stop at DEPTH words
      fill_exp(32'h0000_3000, 20);
      wait_pct = 0; ready_pct = 0; lat = 2;
      start_address = 32'h0000_3000; number_samples = 20; start = 1'b1;
      repeat (40) step();
      chk("bp_accepts", acc_cnt, DEPTH);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_no_read", {31'd0, AM_READ}, 32'd0);
      chk("bp_head", out_data, 32'h0000_3000);
      ready_pct = 100;
      wait_finished("bp");
      chk("bp_words", pop_cnt, 20);
      start = 1'b0;
      step();

      // Reset with reads in flight; late responses must be dropped
      fill_exp(32'h0000_5000, 10);
      wait_pct = 0; ready_pct = 0; lat = 2; acc_limit = 3;
      start_address = 32'h0000_5000; number_samples = 10; start = 1'b1;
      for (int c = 0; c < 100 && acc_cnt < 3; c++) step();
      chk("rstmid_accepts", acc_cnt, 3);
      step();
      RESET = 1'b1; start = 1'b0;
      step();
      chk("rstmid_outputs", {28'd0, AM_READ, out_valid, BUSY, FINISHED}, 32'd0);
      chk("rstmid_addr", AM_ADDR, 32'd0);
      chk("rstmid_data", out_data, 32'd0);
      RESET = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("rstmid_late_drop", {31'd0, out_valid}, 32'd0);
      end
      chk("rstmid_idle", {30'd0, BUSY, FINISHED}, 32'd0);
      acc_limit = 1 << 30;
      repeat (4) step();

      // Randomized transfers
      for (int t = 0; t < 6; t++) begin
         logic [31:0] a, ef;
         int n;
         a  = $urandom;
         n  = $urandom_range(30, 1);
         ef = {a[31:2], 2'b00};
         run_xfer("rand", a, n, $urandom_range(50), $urandom_range(100, 20),
                  $urandom_range(5, 1), ef, ef + 32'(4 * (n - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mic_rd_dma.md
Name: mic_rd_dma

Overview:
- Avalon-MM read master. Fetches a contiguous block of 32-bit sample words from memory (SDRAM via HPS/FPGA bridge) and delivers them, in address order, on a valid/ready stream.
- Counterpart of the mic capture DMA, which writes samples to memory; this block reads them back.
- Consumers are the playback/processing path.
- Software control is start-level, the same as the capture DMA: it sets start_address and number_samples, raises start, waits for FINISHED, then drops start.

Parameters:
- DEPTH, 8, read-data FIFO depth in words. Must be a power of 2, ≥2. It also caps outstanding reads.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high.
- AM_ADDR  out  32  byte address of the read. Always word aligned.
- AM_BURSTCOUNT  out  3  constant 1.
- AM_BYTEENABLE  out  4  constant 4'hF.
- AM_READ  out  1  read request.
- AM_WAITREQUEST  in  1  slave stall.
- AM_READDATA  in  32  returned word.
- AM_READDATAVALID  in  1  AM_READDATA is valid this cycle.
- start  in  1  level. Begin the transfer; hold it high until FINISHED is seen.
- start_address  in  32  first byte address. Bits [1:0] are ignored and forced to 0.
- number_samples  in  32  number of words to read. 0 is legal.
- out_data  out  32  stream data, taken from the FIFO head.
- out_valid  out  1  FIFO is not empty.
- out_ready  in  1  consumer accepts the word.
- BUSY  out  1  high in ISSUE or DRAIN.
- FINISHED  out  1  high in DONE.

Behaviour:
- Reset values:
  - AM_READ=0, AM_ADDR=0, out_valid=0, out_data=0, BUSY=0, FINISHED=0.
  - State IDLE. FIFO empty. Counters outstanding=0 and remaining=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and number_samples≠0 → ISSUE. Latch addr={start_address[31:2],2'b00} and remaining=number_samples.
  - start=1 and number_samples=0 → DONE directly. No bus activity.
- ISSUE:
  - AM_READ = (remaining≠0) && (outstanding + fifo_count < DEPTH). This is combinational from registers. AM_ADDR=addr.
  - Accept = AM_READ && !AM_WAITREQUEST. On accept: addr+=4, remaining-=1, outstanding+=1.
  - Stall stability: outstanding+fifo_count never increases while stalled. Therefore AM_READ and AM_ADDR stay stable during AM_WAITREQUEST, as Avalon requires.
  - Transition: remaining reaches 0 (on accept) → DRAIN.
- Any state, AM_READDATAVALID:
  - Push AM_READDATA into the FIFO and decrement outstanding.
  - Accept and readdatavalid in the same cycle leave outstanding unchanged.
  - In IDLE or DONE, readdatavalid is discarded. This covers stale responses after a reset.
- DRAIN:
  - AM_READ=0, AM_ADDR=0.
  - outstanding=0 and FIFO empty → DONE.
- DONE:
  - FINISHED=1.
  - start=0 → IDLE. start still 1 → remain in DONE; no re-trigger.
- Stream:
  - out_valid = !fifo_empty. out_data = FIFO head (show-ahead).
  - Pop when out_valid && out_ready.
  - Latency: readdatavalid at cycle t → out_valid at t+1.
  - Push and pop in the same cycle are both performed; fifo_count is unchanged.
- Flow control:
  - The credit rule guarantees the FIFO never overflows.
  - out_ready=0 indefinitely stalls issue after DEPTH words are in flight or buffered.
- Address arithmetic:
  - 32-bit, wraps modulo 2^32 with no error.
  - remaining is 32-bit unsigned.
- Reset mid-operation: all state, counters and FIFO are cleared on the next edge. Responses in flight are then dropped because the block is in IDLE.
- Latency: first AM_READ is asserted the cycle after start is sampled in IDLE.

Decomposition:
- Package mic_dma_pkg holds:
  - State enum rd_state_t {IDLE, ISSUE, DRAIN, DONE}.
  - Constants: AM_BURST_ONE=3'd1, AM_BE_ALL=4'hF, WORD_BYTES=4.
- Sub-module mic_sync_fifo:
  - Parameters: width 32, DEPTH.
  - Show-ahead output; ports push, pop, count, empty, full.
  - Simultaneous push/pop supported. Synchronous RESET.

Test Plan:
- Normal transfer: N=4, start_address=0x1000, memory latency 2, data=addr, out_ready=1 → four reads at 0x1000/04/08/0C; out_data 0x1000..0x100C in order; FINISHED=1; start=0 → IDLE next cycle.
- Waitrequest stall: AM_WAITREQUEST held 3 cycles on 2nd read → AM_READ=1 and AM_ADDR=0x1004 stable for all 3 cycles; exactly 4 accepts; no duplicate data.
- Backpressure: N=20, DEPTH=8, out_ready=0 → accepted reads stop at 8; FIFO count=8; no overflow; out_ready=1 → all 20 words delivered, FINISHED=1.
- Zero length: number_samples=0, start=1 → FINISHED=1 one cycle later; AM_READ never asserted.
- Concurrency and reset: accept, readdatavalid and pop coincide → outstanding and fifo_count unchanged. RESET after 3 accepts with 2 outstanding → all outputs 0 next cycle; 2 late readdatavalid pulses ignored; out_valid stays 0.
- Unaligned start: start_address=0x2003, N=2 → reads at 0x2000 and 0x2004.
